// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared codes, denominations, state and coin types for ticket vending
//
// Purpose: common definitions used by the ticket dispense controller and its
// coin inventory.
// Contents: ticket select codes, money denominations, dispense FSM state enum,
// coin denomination encoding and a helper mapping a coin to its value.
package vend_pkg;

  localparam logic [1:0] SEL_NONE      = 2'b00;
  localparam logic [1:0] SEL_HOWRAH    = 2'b01;
  localparam logic [1:0] SEL_MANIKARAN = 2'b10;
  localparam logic [1:0] SEL_ESPLANADE = 2'b11;

  localparam logic [4:0] M_5  = 5'd5;
  localparam logic [4:0] M_10 = 5'd10;
  localparam logic [4:0] M_20 = 5'd20;

  typedef enum logic [2:0] {
    IDLE,
    TICKET,
    PAY_SEL,
    PAY_WAIT,
    DONE,
    SHORT,
    FAULT
  } state_t;

  typedef enum logic {
    DEN_5  = 1'b0,
    DEN_10 = 1'b1
  } coin_den_t;

  function automatic logic [4:0] den_value(input coin_den_t den);
    return (den == DEN_10) ? M_10 : M_5;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// rtl/coin_inventory.sv - saturating 5- and 10-unit coin counters for the hopper
//
// Purpose: tracks how many coins of each denomination remain in the hopper.
// Ports:
//   clk, rst            clock, asynchronous active-low reset (loads INIT values)
//   load                reload both counters to their INIT values
//   dec, dec_den        one coin of denomination dec_den was ejected
//   c5_cnt, c10_cnt     current inventory
//   c5_avail, c10_avail counter is non-zero
module coin_inventory
  import vend_pkg::*;
#(
  parameter int unsigned C5_INIT  = 20,
  parameter int unsigned C10_INIT = 20,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  coin_den_t        dec_den,
  output logic [CNT_W-1:0] c5_cnt,
  output logic [CNT_W-1:0] c10_cnt,
  output logic             c5_avail,
  output logic             c10_avail
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c5_cnt  <= CNT_W'(C5_INIT);
      c10_cnt <= CNT_W'(C10_INIT);
    end else if (load) begin
      c5_cnt  <= CNT_W'(C5_INIT);
      c10_cnt <= CNT_W'(C10_INIT);
    end else if (dec) begin
      // An ejection reported against an empty counter holds at zero.
      if (dec_den == DEN_10) begin
        if (c10_cnt != '0) c10_cnt <= c10_cnt - CNT_W'(1);
      end else begin
        if (c5_cnt != '0) c5_cnt <= c5_cnt - CNT_W'(1);
      end
    end
  end

  assign c5_avail  = (c5_cnt != '0);
  assign c10_avail = (c10_cnt != '0);

endmodule

// File: rtl/ticket_dispense_ctrl.sv
// rtl/ticket_dispense_ctrl.sv - prints a granted ticket, then pays change as 10/5 coins
//
// Purpose: downstream of the vending FSM; drives the printer and coin hopper
// handshakes, tracks coin inventory and flags short payment and ack timeouts.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   howrah, manikaran, esplanade   one-cycle ticket grants (priority in that order)
//   change                         change owed, sampled with the grant
//   refill                         reload inventory (IDLE only)
//   tkt_req, tkt_sel, tkt_ack      printer handshake and ticket code
//   coin_req, coin_den, coin_ack   hopper handshake (0 = 5-unit, 1 = 10-unit)
//   busy, done, short_pay, owed    status; owed holds the unpaid remainder
//   overrun                        grant seen while busy
//   fault                          sticky ack timeout, cleared only by reset
//   c5_cnt, c10_cnt                coin inventory
module ticket_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned C5_INIT  = 20,
  parameter int unsigned C10_INIT = 20,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             howrah,
  input  logic             manikaran,
  input  logic             esplanade,
  input  logic [4:0]       change,
  input  logic             refill,
  output logic             tkt_req,
  output logic [1:0]       tkt_sel,
  input  logic             tkt_ack,
  output logic             coin_req,
  output logic             coin_den,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             short_pay,
  output logic [4:0]       owed,
  output logic             overrun,
  output logic             fault,
  output logic [CNT_W-1:0] c5_cnt,
  output logic [CNT_W-1:0] c10_cnt
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic [4:0]      rem, rem_nx;
  logic [1:0]      sel_nx;
  logic [4:0]      owed_nx;
  coin_den_t       den, den_nx;
  logic [WD_W-1:0] wd_cnt;
  logic            grant, wd_expired, coin_taken, inv_load;
  logic            c5_avail, c10_avail;

  assign grant      = howrah | manikaran | esplanade;
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign coin_taken = (state == PAY_WAIT) && coin_ack;
  assign inv_load   = (state == IDLE) && refill;
  assign coin_den   = den;

  coin_inventory #(
    .C5_INIT (C5_INIT),
    .C10_INIT(C10_INIT),
    .CNT_W   (CNT_W)
  ) u_inv (
    .clk      (clk),
    .rst      (rst),
    .load     (inv_load),
    .dec      (coin_taken),
    .dec_den  (den),
    .c5_cnt   (c5_cnt),
    .c10_cnt  (c10_cnt),
    .c5_avail (c5_avail),
    .c10_avail(c10_avail)
  );

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    sel_nx   = tkt_sel;
    owed_nx  = owed;
    den_nx   = den;
    unique case (state)
      IDLE: begin
        if (grant) begin
          state_nx = TICKET;
          rem_nx   = change;
          owed_nx  = '0;
          if (howrah)         sel_nx = SEL_HOWRAH;
          else if (manikaran) sel_nx = SEL_MANIKARAN;
          else                sel_nx = SEL_ESPLANADE;
        end
      end
      TICKET: begin
        if (tkt_ack)         state_nx = PAY_SEL;
        else if (wd_expired) state_nx = FAULT;
      end
      PAY_SEL: begin
        // Greedy: largest coin first, falling back to 5s when 10s run out.
        if (rem == '0) begin
          state_nx = DONE;
        end else if (rem >= M_10 && c10_avail) begin
          den_nx   = DEN_10;
          state_nx = PAY_WAIT;
        end else if (rem >= M_5 && c5_avail) begin
          den_nx   = DEN_5;
          state_nx = PAY_WAIT;
        end else begin
          owed_nx  = rem;
          state_nx = SHORT;
        end
      end
      PAY_WAIT: begin
        if (coin_ack) begin
          rem_nx   = rem - den_value(den);
          state_nx = PAY_SEL;
        end else if (wd_expired) begin
          state_nx = FAULT;
        end
      end
      DONE:    state_nx = IDLE;
      SHORT:   state_nx = IDLE;
      FAULT:   state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rem       <= '0;
      tkt_sel   <= SEL_NONE;
      owed      <= '0;
      den       <= DEN_5;
      wd_cnt    <= '0;
      tkt_req   <= 1'b0;
      coin_req  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short_pay <= 1'b0;
      overrun   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      rem       <= rem_nx;
      tkt_sel   <= sel_nx;
      owed      <= owed_nx;
      den       <= den_nx;
      if (state_nx != state)
        wd_cnt <= '0;
      else if (state == TICKET || state == PAY_WAIT)
        wd_cnt <= wd_cnt + WD_W'(1);
      tkt_req   <= (state_nx == TICKET);
      coin_req  <= (state_nx == PAY_WAIT);
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
      short_pay <= (state_nx == SHORT);
      fault     <= (state_nx == FAULT);
      overrun   <= grant && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_ticket_dispense_ctrl.sv
// tb/tb_ticket_dispense_ctrl.sv - scoreboard bench for ticket_dispense_ctrl
module tb_ticket_dispense_ctrl;

  localparam int C5_INIT  = 20;
  localparam int C10_INIT = 20;
  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 40;

  localparam int K_TKT   = 0;
  localparam int K_COIN  = 1;
  localparam int K_DONE  = 2;
  localparam int K_SHORT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             howrah = 1'b0, manikaran = 1'b0, esplanade = 1'b0;
  logic [4:0]       change = '0;
  logic             refill = 1'b0;
  logic             tkt_req, tkt_ack = 1'b0;
  logic [1:0]       tkt_sel;
  logic             coin_req, coin_den, coin_ack = 1'b0;
  logic             busy, done, short_pay, overrun, fault;
  logic [4:0]       owed;
  logic [CNT_W-1:0] c5_cnt, c10_cnt;

  ticket_dispense_ctrl #(
    .C5_INIT (C5_INIT),
    .C10_INIT(C10_INIT),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .howrah   (howrah),
    .manikaran(manikaran),
    .esplanade(esplanade),
    .change   (change),
    .refill   (refill),
    .tkt_req  (tkt_req),
    .tkt_sel  (tkt_sel),
    .tkt_ack  (tkt_ack),
    .coin_req (coin_req),
    .coin_den (coin_den),
    .coin_ack (coin_ack),
    .busy     (busy),
    .done     (done),
    .short_pay(short_pay),
    .owed     (owed),
    .overrun  (overrun),
    .fault    (fault),
    .c5_cnt   (c5_cnt),
    .c10_cnt  (c10_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0, bad = 0;
  int  exp_ovr = 0, got_ovr = 0;
  bit  ack_en = 1'b1;
  int  m_c5 = C5_INIT, m_c10 = C10_INIT, m_owed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_value", val, e.val);
    end
  endtask

  // Monitor: compares every completed handshake and status pulse with the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (tkt_req && tkt_ack)   observe(K_TKT, int'(tkt_sel));
        if (coin_req && coin_ack) observe(K_COIN, coin_den ? 10 : 5);
        if (done)                 observe(K_DONE, 0);
        if (short_pay)            observe(K_SHORT, int'(owed));
        if (overrun)              got_ovr++;
      end
    end
  end

  // Printer and hopper: random ack latency, plus stray acks while the request is low.
  initial begin
    int td = 0, cd = 0;
    forever begin
      @(posedge clk);
      #2;
      tkt_ack  = 1'b0;
      coin_ack = 1'b0;
      if (ack_en) begin
        if (tkt_req) begin
          if (td == 0) begin tkt_ack = 1'b1; td = $urandom_range(0, 3); end
          else td--;
        end else if ($urandom_range(0, 7) == 0) tkt_ack = 1'b1;
        if (coin_req) begin
          if (cd == 0) begin coin_ack = 1'b1; cd = $urandom_range(0, 3); end
          else cd--;
        end else if ($urandom_range(0, 7) == 0) coin_ack = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference model: ticket, then largest-coin-first payment from inventory.
  task automatic expect_txn(input logic [2:0] g, input int ch, input bit rf);
    int rem = ch;
    if (rf) begin m_c5 = C5_INIT; m_c10 = C10_INIT; end
    m_owed = 0;
    exp_q.push_back('{K_TKT, g[0] ? 1 : (g[1] ? 2 : 3)});
    while (rem > 0) begin
      if (rem >= 10 && m_c10 > 0) begin
        exp_q.push_back('{K_COIN, 10}); rem -= 10; m_c10--;
      end else if (rem >= 5 && m_c5 > 0) begin
        exp_q.push_back('{K_COIN, 5}); rem -= 5; m_c5--;
      end else break;
    end
    if (rem == 0) exp_q.push_back('{K_DONE, 0});
    else begin
      exp_q.push_back('{K_SHORT, rem});
      m_owed = rem;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    chk("idle_reached", busy, 0);
  endtask

  task automatic drive_grant(input logic [2:0] g, input int ch, input bit rf);
    {esplanade, manikaran, howrah} = g;
    change = 5'(ch);
    refill = rf;
    @(negedge clk);
    {esplanade, manikaran, howrah} = 3'b000;
    refill = 1'b0;
    change = 5'($urandom_range(0, 31));
  endtask

  task automatic issue(input logic [2:0] g, input int ch, input bit rf);
    wait_idle();
    expect_txn(g, ch, rf);
    drive_grant(g, ch, rf);
  endtask

  task automatic finish_txn();
    wait_idle();
    chk("c5_cnt", c5_cnt, m_c5);
    chk("c10_cnt", c10_cnt, m_c10);
    chk("owed", owed, m_owed);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_flags", {tkt_req, coin_req, busy, done, short_pay, overrun, fault}, 0);
    chk("reset_tkt_sel", tkt_sel, 0);
    chk("reset_owed", owed, 0);
    chk("reset_c5", c5_cnt, C5_INIT);
    chk("reset_c10", c10_cnt, C10_INIT);
    rst = 1'b1;
    @(negedge clk);

    // Manikaran, change 10: one 10-unit coin.
    issue(3'b010, 10, 1'b0);
    chk("tkt_req_after_grant", tkt_req, 1);
    chk("tkt_sel_manikaran", tkt_sel, 2);
    finish_txn();

    // Change below the smallest coin, then zero change (clears owed).
    issue(3'b001, 3, 1'b0);
    finish_txn();
    issue(3'b100, 0, 1'b0);
    finish_txn();

    // All three grants at once, then grants while printing.
    issue(3'b111, 7, 1'b0);
    chk("tkt_sel_priority", tkt_sel, 1);
    drive_grant(3'b111, 12, 1'b0);
    exp_ovr++;
    chk("overrun_pulse", overrun, 1);
    finish_txn();

    // Drain the 10s, pay with 5s only, then drain 5s down to one coin.
    while (m_c10 > 0) begin issue(3'b001, 30, 1'b0); finish_txn(); end
    issue(3'b100, 5, 1'b0);
    finish_txn();
    while (m_c5 > 1) begin issue(3'b010, (m_c5 >= 4) ? 15 : 5, 1'b0); finish_txn(); end
    issue(3'b001, 15, 1'b0);
    finish_txn();
    chk("owed_short_10", owed, 10);
    issue(3'b100, 5, 1'b0);
    finish_txn();

    // Refill while busy is ignored; refill in IDLE reloads.
    issue(3'b010, 0, 1'b0);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    finish_txn();
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    m_c5 = C5_INIT; m_c10 = C10_INIT;
    @(negedge clk);
    chk("refill_c5", c5_cnt, C5_INIT);
    chk("refill_c10", c10_cnt, C10_INIT);

    // Random transactions, occasionally refilling in the same cycle as the grant.
    for (int i = 0; i < 30; i++) begin
      issue(3'($urandom_range(1, 7)), $urandom_range(0, 31), ($urandom_range(0, 4) == 0));
      finish_txn();
    end

    // Reset with a coin request in flight.
    issue(3'b010, 20, 1'b1);
    n = 0;
    while (!coin_req && n < 100) begin @(negedge clk); n++; end
    chk("coin_req_seen", coin_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_drop_coin_req", coin_req, 0);
    chk("async_drop_busy", busy, 0);
    exp_q.delete();
    m_c5 = C5_INIT; m_c10 = C10_INIT; m_owed = 0;
    @(negedge clk);
    chk("midreset_c10", c10_cnt, C10_INIT);
    rst = 1'b1;
    @(negedge clk);

    // Ack timeout; grants in FAULT; reset restores inventory.
    issue(3'b001, 15, 1'b0);
    finish_txn();
    ack_en = 1'b0;
    drive_grant(3'b001, 5, 1'b0);
    n = 0;
    while (!fault && n < TIMEOUT + 20) begin @(negedge clk); n++; end
    chk("fault_set", fault, 1);
    chk("fault_tkt_req", tkt_req, 0);
    chk("fault_busy", busy, 1);
    ack_en = 1'b1;
    drive_grant(3'b100, 10, 1'b0);
    exp_ovr++;
    chk("fault_overrun", overrun, 1);
    repeat (4) @(negedge clk);
    chk("fault_no_ticket", {tkt_req, coin_req}, 0);
    chk("fault_sticky", fault, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("fault_cleared", fault, 0);
    chk("post_fault_c5", c5_cnt, C5_INIT);
    chk("post_fault_c10", c10_cnt, C10_INIT);
    m_c5 = C5_INIT; m_c10 = C10_INIT; m_owed = 0;
    rst = 1'b1;
    @(negedge clk);

    issue(3'b100, 25, 1'b0);
    finish_txn();

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("overrun_count", got_ovr, exp_ovr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ticket_dispense_ctrl.md
# ticket_dispense_ctrl

Downstream stage of the ticket vending FSM. Consumes its one-cycle ticket grants (`howrah`, `manikaran`, `esplanade`) and the `change` amount. Drives the ticket printer, then pays the change as a sequence of 10- and 5-unit coin ejections through a handshaked coin hopper. Tracks hopper coin inventory and flags shortfalls and hardware faults.

## Interface
- `C5_INIT`, 20: 5-unit coins loaded at reset and on refill.
- `C10_INIT`, 20: 10-unit coins loaded at reset and on refill.
- `CNT_W`, 8: width of the inventory counters.
- `TIMEOUT`, 1000: maximum cycles to wait for any ack before faulting.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `howrah`, `manikaran`, `esplanade`  in  1 each  ticket grant strobes from the vending FSM.
- `change`  in  5  change owed; sampled in the cycle a grant strobe is high.
- `refill`  in  1  reloads both counters to their INIT values; honoured only in IDLE.
- `tkt_req`  out  1  printer request; held until `tkt_ack`.
- `tkt_sel`  out  2  ticket code: 01 howrah, 10 manikaran, 11 esplanade. Valid while `tkt_req` is high.
- `tkt_ack`  in  1  printer done.
- `coin_req`  out  1  hopper eject request; held until `coin_ack`.
- `coin_den`  out  1  coin to eject: 0 = 5-unit, 1 = 10-unit. Stable while `coin_req` is high.
- `coin_ack`  in  1  hopper ejected one coin.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse when a transaction completes in full.
- `short_pay`  out  1  one-cycle pulse when exact change cannot be paid.
- `owed`  out  5  unpaid remainder; latched at `short_pay`, cleared at the next accepted grant.
- `overrun`  out  1  one-cycle pulse when a grant arrives while `busy`.
- `fault`  out  1  sticky; set on an ack timeout.
- `c5_cnt`, `c10_cnt`  out  CNT_W  current coin inventory.

## Operation
- States: IDLE, TICKET, PAY_SEL, PAY_WAIT, DONE, SHORT, FAULT.
- Reset values:
  - state = IDLE.
  - All request, pulse and flag outputs = 0; `tkt_sel` = 00; `owed` = 0.
  - `c5_cnt` = C5_INIT; `c10_cnt` = C10_INIT.
- IDLE:
  - Any grant high → latch the ticket code and `rem` = `change`, go to TICKET.
  - Several grants high in the same cycle: priority howrah > manikaran > esplanade. Only one ticket is issued.
- TICKET: `tkt_req` = 1. `tkt_ack` → PAY_SEL.
- PAY_SEL evaluates in this priority order:
  - `rem` = 0 → DONE.
  - `rem` ≥ 10 and `c10_cnt` > 0 → `coin_den` = 1, go to PAY_WAIT.
  - `rem` ≥ 5 and `c5_cnt` > 0 → `coin_den` = 0, go to PAY_WAIT.
  - Otherwise → SHORT. This covers a remainder of 1–4 and empty inventory.
- PAY_WAIT: `coin_req` = 1. On `coin_ack`:
  - `rem` -= the denomination.
  - The matching counter decrements. It saturates at 0 and never wraps.
  - Go to PAY_SEL.
- DONE: `done` = 1 for one cycle → IDLE.
- SHORT: `short_pay` = 1 and `owed` = `rem` for one cycle → IDLE.
- Watchdog:
  - A counter runs in TICKET and PAY_WAIT and clears on every state change.
  - Reaching TIMEOUT → FAULT.
  - FAULT holds `fault` = 1 and all requests = 0. It is left only by reset.
- Grants while `busy`: ignored, `overrun` pulsed, no state change.
- `refill` outside IDLE: ignored.
- `refill` in the same cycle as a grant in IDLE: both take effect.
- Reset mid-transaction: the transaction is abandoned and nothing is owed. Any request in flight drops asynchronously.

## Timing
- All outputs are registered.
- Grant sampled at edge N → `tkt_req` high from N+1.
- `tkt_ack` sampled at edge M → `tkt_req` low from M+1 → `coin_req` high from M+2 (one PAY_SEL cycle).
- Each coin costs ack latency + 2 cycles.
- `done` follows the final `coin_ack` by 2 cycles. With zero change, `done` follows `tkt_ack` by 2 cycles.
- The earliest new grant is accepted in the cycle after DONE or SHORT.
- An ack arriving while its request is low is ignored.

## Structure
- Shared package `vend_pkg` holds:
  - Ticket codes SEL_HOWRAH/SEL_MANIKARAN/SEL_ESPLANADE.
  - Denominations M_5/M_10/M_20.
  - The state enum.
  - Coin denomination encoding.
- Sub-module `coin_inventory` owns both saturating counters: load-on-refill/reset, decrement-by-denomination, and the non-zero status flags.

## Test plan
- Manikaran grant with `change` = 10, acks after 3 cycles → `tkt_sel` = 10, one coin with `coin_den` = 1, `done`, `c10_cnt` 20→19.
- Esplanade grant with `change` = 5, `c10_cnt` = 0 → one 5-unit coin, `done`.
- Howrah grant with `change` = 15, C10_INIT = 0, C5_INIT = 1 → one 5-unit coin, then `short_pay` with `owed` = 10.
- Grants during TICKET, and all three grants in one cycle → `overrun` pulses; a single howrah ticket issued.
- `tkt_ack` withheld for TIMEOUT cycles → `fault` = 1, `tkt_req` = 0. Grants ignored until `rst` low; after reset, counters restored to INIT.
- `change` = 3 with a howrah grant → ticket issued, then `short_pay` with `owed` = 3, no coins ejected.
